// File: rtl/rc5_cmd_queue_if.sv
// Bus bundle between the RC5 receiver / CPU CSR side and the command queue.
// The frame pulse and the CSR bus share one bundle; clock and reset stay
// plain ports on the modules that use it.
interface rc5_cmd_queue_if;
    logic        frame_valid;
    logic [12:0] frame_data;
    logic [14:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic [31:0] csr_do;
    logic        irq;

    // Driver side: receiver pulses plus the CPU issuing CSR accesses.
    modport master (
        output frame_valid, frame_data, csr_a, csr_we, csr_di,
        input  csr_do, irq
    );

    // Queue side.
    modport slave (
        input  frame_valid, frame_data, csr_a, csr_we, csr_di,
        output csr_do, irq
    );
endinterface

// File: rtl/rc5_cmd_queue.sv
// RC5 command queue: drops auto-repeat frames from a held key, buffers the
// surviving frames in an 8-deep FIFO and exposes them through four CSRs
// (DATA, STAT, CTRL, REPCNT) with a level interrupt while frames are pending.
module rc5_cmd_queue #(
    parameter logic [4:0]  csr_addr       = 5'h0,
    parameter int unsigned clk_freq       = 100000000,
    parameter int unsigned repeat_timeout = clk_freq / 1000 * 120
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    rc5_cmd_queue_if.slave    bus
);

    // A frame arriving k cycles after the previous one is a repeat for
    // k <= repeat_timeout-1, so the timer is loaded with that value.
    localparam logic [31:0] TIMER_RELOAD = 32'(repeat_timeout - 1);

    // Frame storage; no reset, the pointers define what is valid.
    logic [12:0] mem_q [8];

    logic [2:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  wr_ptr_q, wr_ptr_d;
    logic [3:0]  level_q, level_d;
    logic        overflow_q, overflow_d;
    logic [15:0] repcnt_q, repcnt_d;
    logic [1:0]  ctrl_q, ctrl_d;          // [0] filter_en, [1] irq_en
    logic [12:0] last_frame_q, last_frame_d;
    logic        last_valid_q, last_valid_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] csr_do_q, csr_do_d;
    logic        irq_q, irq_d;

    logic        sel;
    logic [1:0]  idx;
    logic        wr;
    logic        empty;
    logic        full;
    logic        pop;
    logic        is_repeat;
    logic        push_req;
    logic        push;
    logic        ovf_event;
    logic [12:0] head;
    logic [31:0] rdata;

    // Address bits and data bits outside the decoded fields are don't-care.
    logic unused_ok;
    assign unused_ok = ^{bus.csr_a[9:2], bus.csr_di[31:9], bus.csr_di[7:2], 32'(clk_freq)};

    // Decode CSR access, classify the incoming frame and resolve push/pop.
    always_comb begin
        sel       = (bus.csr_a[14:10] == csr_addr);
        idx       = bus.csr_a[1:0];
        wr        = sel & bus.csr_we;
        empty     = (level_q == 4'd0);
        full      = (level_q == 4'd8);
        pop       = wr & (idx == 2'd0) & ~empty;
        is_repeat = ctrl_q[0] & last_valid_q & (bus.frame_data == last_frame_q);
        push_req  = bus.frame_valid & ~is_repeat;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push      = push_req & (~full | pop);
        ovf_event = push_req & full & ~pop;
        head      = empty ? 13'd0 : mem_q[rd_ptr_q];
    end

    // Next-state for FIFO bookkeeping, status and control registers.
    always_comb begin
        rd_ptr_d   = rd_ptr_q + 3'(pop);
        wr_ptr_d   = wr_ptr_q + 3'(push);
        level_d    = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 4'd1;
            2'b01:   level_d = level_q - 4'd1;
            default: level_d = level_q;
        endcase

        overflow_d = overflow_q;
        if (wr && (idx == 2'd1) && bus.csr_di[8])
            overflow_d = 1'b0;
        // A fresh overflow wins over a simultaneous clear.
        if (ovf_event)
            overflow_d = 1'b1;

        ctrl_d = ctrl_q;
        if (wr && (idx == 2'd2))
            ctrl_d = bus.csr_di[1:0];

        repcnt_d = repcnt_q;
        if (wr && (idx == 2'd3))
            repcnt_d = 16'd0;
        else if (bus.frame_valid && is_repeat && (repcnt_q != 16'hFFFF))
            repcnt_d = repcnt_q + 16'd1;

        irq_d = ctrl_q[1] & (level_q != 4'd0);
    end

    // Next-state for the repeat-filter memory and hold timer.
    always_comb begin
        last_frame_d = last_frame_q;
        last_valid_d = last_valid_q;
        timer_d      = timer_q;
        if (bus.frame_valid) begin
            last_frame_d = bus.frame_data;
            last_valid_d = 1'b1;
            timer_d      = TIMER_RELOAD;
        end else begin
            if (timer_q != 32'd0)
                timer_d = timer_q - 32'd1;
            // Drop the remembered frame on the edge the timer reaches zero.
            if (timer_q <= 32'd1)
                last_valid_d = 1'b0;
        end
    end

    // CSR read mux; data reflects state in the addressing cycle.
    always_comb begin
        case (idx)
            2'd0:    rdata = {~empty, 18'd0, head};
            2'd1:    rdata = {22'd0, empty, overflow_q, 4'd0, level_q};
            2'd2:    rdata = {30'd0, ctrl_q};
            default: rdata = {16'd0, repcnt_q};
        endcase
        csr_do_d = sel ? rdata : 32'd0;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rd_ptr_q     <= 3'd0;
            wr_ptr_q     <= 3'd0;
            level_q      <= 4'd0;
            overflow_q   <= 1'b0;
            repcnt_q     <= 16'd0;
            ctrl_q       <= 2'b11;
            last_frame_q <= 13'd0;
            last_valid_q <= 1'b0;
            timer_q      <= 32'd0;
            csr_do_q     <= 32'd0;
            irq_q        <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            repcnt_q     <= repcnt_d;
            ctrl_q       <= ctrl_d;
            last_frame_q <= last_frame_d;
            last_valid_q <= last_valid_d;
            timer_q      <= timer_d;
            csr_do_q     <= csr_do_d;
            irq_q        <= irq_d;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge sys_clk) begin
        if (sys_rst_n && push)
            mem_q[wr_ptr_q] <= bus.frame_data;
    end

    assign bus.csr_do = csr_do_q;
    assign bus.irq    = irq_q;

endmodule
